// File: rtl/fifo_stream_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_adapter_pkg
// Description : Shared widths, depths and helpers for the FIFO-to-stream adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_stream_adapter_pkg;

    localparam int DATA_W            = 8;
    localparam int SKID_DEPTH        = 2;
    localparam int FRAME_CNT_W       = 16;
    localparam int FRAME_LEN_DEFAULT = 4;
    localparam int BEAT_W            = 8;
    localparam int OCC_W             = $clog2(SKID_DEPTH + 1);

    function automatic logic [BEAT_W-1:0] beat_next(
        input logic [BEAT_W-1:0] beat,
        input logic              is_last
    );
        return is_last ? '0 : beat + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_adapter_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buf
// Description : Two-entry first-in first-out skid buffer; head entry always
//               presented on o_head.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buf
    import fifo_stream_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [OCC_W-1:0]  o_occ
);

    logic [DATA_W-1:0] r_head_q;
    logic [DATA_W-1:0] r_tail_q;
    logic [OCC_W-1:0]  r_occ_q;
    logic [DATA_W-1:0] w_head_d;
    logic [DATA_W-1:0] w_tail_d;
    logic [OCC_W-1:0]  w_occ_d;

    always_comb begin
        w_head_d = r_head_q;
        w_tail_d = r_tail_q;
        w_occ_d  = r_occ_q;
        case (r_occ_q)
            2'd0: begin
                if (i_push) begin
                    w_head_d = i_push_data;
                    w_occ_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({i_push, i_pop})
                    2'b10: begin
                        w_tail_d = i_push_data;
                        w_occ_d  = 2'd2;
                    end
                    2'b01:   w_occ_d  = 2'd0;
                    2'b11:   w_head_d = i_push_data;
                    default: ;
                endcase
            end
            default: begin
                // Full: a push is only legal alongside a pop, which shifts the tail up.
                if (i_pop) begin
                    w_head_d = r_tail_q;
                    if (i_push) begin
                        w_tail_d = i_push_data;
                    end else begin
                        w_occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q <= '0;
            r_tail_q <= '0;
            r_occ_q  <= '0;
        end else begin
            r_head_q <= w_head_d;
            r_tail_q <= w_tail_d;
            r_occ_q  <= w_occ_d;
        end
    end

    assign o_head = r_head_q;
    assign o_occ  = r_occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (r_occ_q == 2'd2)));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_occ_q == 2'd0)));

endmodule
`default_nettype wire

// File: rtl/fifo_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_adapter
// Description : Drains a registered-output FIFO into a framed valid/ready stream
//               with m_last every FRAME_LEN bytes and a delivered-frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_adapter
    import fifo_stream_adapter_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      fifo_dout,
    input  logic                   fifo_empty,
    input  logic                   fifo_wr,
    output logic                   fifo_rd,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(FRAME_LEN - 1);

    logic                   r_inflight_q;
    logic                   w_inflight_d;
    logic [BEAT_W-1:0]      r_beat_q;
    logic [BEAT_W-1:0]      w_beat_d;
    logic [FRAME_CNT_W-1:0] r_frame_cnt_q;
    logic [FRAME_CNT_W-1:0] w_frame_cnt_d;

    logic [DATA_W-1:0]      w_head;
    logic [OCC_W-1:0]       w_occ;
    logic                   w_pop;
    logic                   w_accept;
    logic [OCC_W:0]         w_level;

    stream_skid_buf u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight_q),
        .i_push_data (fifo_dout),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    // Outputs are forced quiet during reset, before the registers themselves clear.
    assign m_valid = !rst && (w_occ != '0);
    assign m_data  = rst ? '0 : w_head;
    assign m_last  = m_valid && (r_beat_q == c_last_beat);
    assign w_pop   = m_valid && m_ready;

    // Slots committed next cycle: buffered + in flight - leaving now.
    assign w_level  = {1'b0, w_occ} + (OCC_W+1)'(r_inflight_q) - (OCC_W+1)'(w_pop);
    assign fifo_rd  = !rst && !fifo_empty && (w_level < (OCC_W+1)'(SKID_DEPTH));
    assign w_accept = fifo_rd && !fifo_empty && !fifo_wr;

    always_comb begin
        w_inflight_d  = w_accept;
        w_beat_d      = r_beat_q;
        w_frame_cnt_d = r_frame_cnt_q;
        if (w_pop) begin
            w_beat_d = beat_next(r_beat_q, m_last);
            if (m_last) begin
                w_frame_cnt_d = r_frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight_q  <= 1'b0;
            r_beat_q      <= '0;
            r_frame_cnt_q <= '0;
        end else begin
            r_inflight_q  <= w_inflight_d;
            r_beat_q      <= w_beat_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    assign frame_cnt = r_frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_adapter
// Description : Scoreboard bench for fifo_stream_adapter with a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_adapter;

    localparam int FRAME_LEN = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [7:0]  fifo_dout  = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_wr    = 1'b0;
    logic        fifo_rd;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready    = 1'b0;
    logic        m_last;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] load_q[$];
    logic [7:0] tmp_q[$];
    logic [7:0] wr_data    = 8'h00;
    exp_t       mon_e;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int n_reads    = 0;
    int pop_count  = 0;
    int first_pop  = 0;
    int last_pop   = 0;
    int exp_frames = 0;
    int exp_beat   = 0;
    int r0         = 0;

    always #5 clk = ~clk;

    fifo_stream_adapter #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_cnt  (frame_cnt)
    );

    // FIFO model: registered read data, write has priority over read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd && !fifo_empty && !fifo_wr) begin
            fifo_dout <= fifo_q.pop_front();
            n_reads   <= n_reads + 1;
        end
        if (fifo_wr) fifo_q.push_back(wr_data);
        while (load_q.size() > 0) fifo_q.push_back(load_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_t e;
        e.data   = d;
        e.last   = (exp_beat == FRAME_LEN - 1);
        exp_beat = e.last ? 0 : exp_beat + 1;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [7:0] d);
        load_q.push_back(d);
        push_exp(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            tick();
            k++;
        end
        check("drain_remaining", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_fifo_rd", 16'(fifo_rd), 16'd0);
        check("rst_m_valid", 16'(m_valid), 16'd0);
        check("rst_m_last",  16'(m_last),  16'd0);
        check("rst_m_data",  16'(m_data),  16'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted output byte.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: actual %h required none", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("m_data", 16'(m_data), 16'(mon_e.data));
                    check("m_last", 16'(m_last), 16'(mon_e.last));
                    check("frame_cnt_run", frame_cnt, 16'(exp_frames));
                    if (mon_e.last) exp_frames++;
                end
                pop_count++;
                if (pop_count == 1) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int k;
        // Preload 01..08 while in reset; nothing may be read or presented yet.
        rst     = 1'b1;
        m_ready = 1'b1;
        tick();
        for (int b = 1; b <= 8; b++) load(8'(b));
        tick();
        tick();
        check_reset_outputs();
        check("rst_frame_cnt", frame_cnt, 16'd0);
        tick();
        rst       = 1'b0;
        pop_count = 0;
        k = 0;
        while (pop_count < 8 && k < 50) begin tick(); k++; end
        check("t1_pops", 16'(pop_count), 16'd8);
        check("t1_back_to_back", 16'(last_pop - first_pop), 16'd7);
        tick();
        check("t1_frame_cnt", frame_cnt, 16'd2);

        // Stall: only two bytes leave the FIFO, head holds A0.
        m_ready = 1'b0;
        for (int b = 0; b < 4; b++) load(8'hA0 + 8'(b));
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_m_valid", 16'(m_valid), 16'd1);
            check("t2_m_data_hold", 16'(m_data), 16'h00A0);
            check("t2_fifo_left", 16'(fifo_q.size()), 16'd2);
        end
        tick();
        m_ready = 1'b1;
        wait_drain(20);
        tick();
        check("t2_frame_cnt", frame_cnt, 16'd3);

        // Write strobe blocks every read attempt for three cycles.
        r0 = n_reads;
        fifo_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h11 * 8'(i + 1);
            push_exp(wr_data);
            @(negedge clk);
            check("t3_m_valid", 16'(m_valid), 16'd0);
            if (i > 0) check("t3_rd_retry", 16'(fifo_rd), 16'd1);
            tick();
        end
        fifo_wr = 1'b0;
        check("t3_no_accept", 16'(n_reads - r0), 16'd0);
        wait_drain(20);
        load(8'h44);
        wait_drain(20);
        tick();
        check("t3_frame_cnt", frame_cnt, 16'd4);

        // FIFO runs dry mid-frame; frame resumes when data returns.
        load(8'h51);
        load(8'h52);
        wait_drain(20);
        repeat (3) tick();
        check("t4_idle_valid", 16'(m_valid), 16'd0);
        check("t4_idle_frame_cnt", frame_cnt, 16'd4);
        load(8'h53);
        load(8'h54);
        wait_drain(20);
        tick();
        check("t4_frame_cnt", frame_cnt, 16'd5);

        // Reset with one byte buffered and one in flight: both are discarded.
        m_ready = 1'b0;
        for (int b = 0; b < 6; b++) load(8'hC0 + 8'(b));
        repeat (6) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        rst     = 1'b1;
        exp_q.delete(0);
        exp_q.delete(0);
        tmp_q.delete();
        foreach (exp_q[i]) tmp_q.push_back(exp_q[i].data);
        exp_q.delete();
        exp_beat   = 0;
        exp_frames = 0;
        foreach (tmp_q[i]) push_exp(tmp_q[i]);
        check_reset_outputs();
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("t5_frame_cnt_rst", frame_cnt, 16'd0);
        load(8'hC6);
        wait_drain(20);
        tick();
        check("t5_frame_cnt", frame_cnt, 16'd1);

        // Random backpressure over 1000 random bytes from a clean start.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        exp_beat   = 0;
        exp_frames = 0;
        for (int i = 0; i < 1000; i++) load(8'($urandom_range(0, 255)));
        k = 0;
        while (exp_q.size() != 0 && k < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        check("t6_remaining", 16'(exp_q.size()), 16'd0);
        m_ready = 1'b1;
        tick();
        tick();
        check("t6_frame_cnt", frame_cnt, 16'd250);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
